// File: rtl/lsu_dmem_ctrl_pkg.sv
// ============================================================================
// lsu_dmem_ctrl_pkg : shared constants, state encoding and access-check helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package lsu_dmem_ctrl_pkg;

  localparam int LSU_ADDR_WIDTH = 32;
  localparam int LSU_DATA_WIDTH = 32;
  localparam int LSU_TAG_WIDTH  = 6;

  localparam logic [2:0] LSU_FUNCT3_LB  = 3'd0;
  localparam logic [2:0] LSU_FUNCT3_LH  = 3'd1;
  localparam logic [2:0] LSU_FUNCT3_LW  = 3'd2;
  localparam logic [2:0] LSU_FUNCT3_LBU = 3'd4;
  localparam logic [2:0] LSU_FUNCT3_LHU = 3'd5;
  localparam logic [2:0] LSU_FUNCT3_SB  = 3'd0;
  localparam logic [2:0] LSU_FUNCT3_SH  = 3'd1;
  localparam logic [2:0] LSU_FUNCT3_SW  = 3'd2;

  typedef enum logic [2:0] {
    LSU_ST_IDLE = 3'd0,
    LSU_ST_RD   = 3'd1,
    LSU_ST_LDAT = 3'd2,
    LSU_ST_RMW  = 3'd3,
    LSU_ST_WR   = 3'd4,
    LSU_ST_RESP = 3'd5
  } lsu_state_e;

  function automatic logic lsu_funct3_legal(input logic is_store, input logic [2:0] funct3);
    logic legal;
    legal = 1'b0;
    if (is_store) begin
      legal = (funct3 == LSU_FUNCT3_SB) || (funct3 == LSU_FUNCT3_SH) ||
              (funct3 == LSU_FUNCT3_SW);
    end else begin
      legal = (funct3 == LSU_FUNCT3_LB)  || (funct3 == LSU_FUNCT3_LH)  ||
              (funct3 == LSU_FUNCT3_LW)  || (funct3 == LSU_FUNCT3_LBU) ||
              (funct3 == LSU_FUNCT3_LHU);
    end
    return legal;
  endfunction

  // Only meaningful for legal funct3; illegal codes are reported before alignment.
  function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (funct3)
      3'b001, 3'b101: mis = addr_lo[0];
      3'b010:         mis = (addr_lo != 2'b00);
      default:        mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// lsu_align : load lane extract/extend and store lane merge (combinational)
// Rev 1.0
// ============================================================================
`default_nettype none

module lsu_align
  import lsu_dmem_ctrl_pkg::*;
(
  input  logic [2:0]                i_funct3,
  input  logic [1:0]                i_lane,
  input  logic [LSU_DATA_WIDTH-1:0] i_rd_word,
  input  logic [LSU_DATA_WIDTH-1:0] i_wdata,
  output logic [LSU_DATA_WIDTH-1:0] o_load_data,
  output logic [LSU_DATA_WIDTH-1:0] o_merge_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [4:0]  w_byte_lsb;

  always_comb begin
    w_byte_lsb = {i_lane, 3'b000};
    w_byte     = i_rd_word[w_byte_lsb +: 8];
    w_half     = i_lane[1] ? i_rd_word[31:16] : i_rd_word[15:0];

    o_load_data = i_rd_word;
    case (i_funct3)
      LSU_FUNCT3_LB:  o_load_data = {{24{w_byte[7]}}, w_byte};
      LSU_FUNCT3_LH:  o_load_data = {{16{w_half[15]}}, w_half};
      LSU_FUNCT3_LBU: o_load_data = {24'd0, w_byte};
      LSU_FUNCT3_LHU: o_load_data = {16'd0, w_half};
      default:        o_load_data = i_rd_word;
    endcase

    // Word stores bypass the merge entirely and take the full write data.
    o_merge_word = i_rd_word;
    case (i_funct3)
      LSU_FUNCT3_SB: o_merge_word[w_byte_lsb +: 8] = i_wdata[7:0];
      LSU_FUNCT3_SH: begin
        if (i_lane[1]) o_merge_word[31:16] = i_wdata[15:0];
        else           o_merge_word[15:0]  = i_wdata[15:0];
      end
      default:       o_merge_word = i_wdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_dmem_ctrl.sv
// ============================================================================
// lsu_dmem_ctrl : single-request load/store controller driving dmem directly
// Rev 1.0
// ============================================================================
`default_nettype none

module lsu_dmem_ctrl
  import lsu_dmem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = LSU_ADDR_WIDTH,
  parameter int DATA_WIDTH = LSU_DATA_WIDTH,
  parameter int TAG_WIDTH  = LSU_TAG_WIDTH
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_is_store,
  input  logic [2:0]            i_req_funct3,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  input  logic [TAG_WIDTH-1:0]  i_req_tag,
  output logic                  o_resp_valid,
  input  logic                  i_resp_ready,
  output logic [TAG_WIDTH-1:0]  o_resp_tag,
  output logic [DATA_WIDTH-1:0] o_resp_data,
  output logic                  o_resp_misaligned,
  output logic                  o_resp_illegal,
  input  logic                  i_flush,
  output logic [ADDR_WIDTH-1:0] o_dmem_addr,
  output logic                  o_dmem_wr_en,
  output logic [DATA_WIDTH-1:0] o_dmem_wr_data,
  input  logic [DATA_WIDTH-1:0] i_dmem_rd_data
);

  lsu_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  is_store_q, is_store_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  resp_mis_q, resp_mis_d;
  logic                  resp_ill_q, resp_ill_d;

  logic                  w_accept;
  logic                  w_legal;
  logic                  w_misal;
  logic                  w_load_flush;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic [DATA_WIDTH-1:0] w_merge_word;

  lsu_align u_align (
    .i_funct3     (funct3_q),
    .i_lane       (addr_q[1:0]),
    .i_rd_word    (i_dmem_rd_data),
    .i_wdata      (wdata_q),
    .o_load_data  (w_load_data),
    .o_merge_word (w_merge_word)
  );

  assign o_req_ready = (state_q == LSU_ST_IDLE) && !rst;
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_legal     = lsu_funct3_legal(i_req_is_store, i_req_funct3);
  assign w_misal     = lsu_misaligned(i_req_funct3, i_req_addr[1:0]);
  // Stores are committed at issue, so only loads can be cancelled.
  assign w_load_flush = i_flush && !is_store_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
    is_store_d  = is_store_q;
    tag_d       = tag_q;
    resp_data_d = resp_data_q;
    resp_mis_d  = resp_mis_q;
    resp_ill_d  = resp_ill_q;

    case (state_q)
      LSU_ST_IDLE: begin
        if (w_accept) begin
          addr_d      = i_req_addr;
          wdata_d     = i_req_wdata;
          funct3_d    = i_req_funct3;
          is_store_d  = i_req_is_store;
          tag_d       = i_req_tag;
          resp_data_d = '0;
          resp_ill_d  = !w_legal;
          resp_mis_d  = w_legal && w_misal;
          if (!w_legal || w_misal) begin
            state_d = LSU_ST_RESP;
          end else if (i_req_is_store && (i_req_funct3 == LSU_FUNCT3_SW)) begin
            state_d = LSU_ST_WR;
          end else begin
            state_d = LSU_ST_RD;
          end
        end
      end
      LSU_ST_RD: begin
        if (w_load_flush)    state_d = LSU_ST_IDLE;
        else if (is_store_q) state_d = LSU_ST_RMW;
        else                 state_d = LSU_ST_LDAT;
      end
      LSU_ST_LDAT: begin
        if (w_load_flush) begin
          state_d = LSU_ST_IDLE;
        end else begin
          resp_data_d = w_load_data;
          state_d     = LSU_ST_RESP;
        end
      end
      LSU_ST_RMW:  state_d = LSU_ST_RESP;
      LSU_ST_WR:   state_d = LSU_ST_RESP;
      LSU_ST_RESP: begin
        if (w_load_flush || i_resp_ready) state_d = LSU_ST_IDLE;
      end
      default:     state_d = LSU_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LSU_ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      funct3_q    <= '0;
      is_store_q  <= 1'b0;
      tag_q       <= '0;
      resp_data_q <= '0;
      resp_mis_q  <= 1'b0;
      resp_ill_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      is_store_q  <= is_store_d;
      tag_q       <= tag_d;
      resp_data_q <= resp_data_d;
      resp_mis_q  <= resp_mis_d;
      resp_ill_q  <= resp_ill_d;
    end
  end

  assign o_resp_valid      = (state_q == LSU_ST_RESP);
  assign o_resp_tag        = tag_q;
  assign o_resp_data       = resp_data_q;
  assign o_resp_misaligned = resp_mis_q;
  assign o_resp_illegal    = resp_ill_q;

  assign o_dmem_addr    = {2'b00, addr_q[ADDR_WIDTH-1:2]};
  assign o_dmem_wr_en   = (state_q == LSU_ST_WR) || (state_q == LSU_ST_RMW);
  assign o_dmem_wr_data = (state_q == LSU_ST_WR)  ? wdata_q :
                          (state_q == LSU_ST_RMW) ? w_merge_word : '0;

endmodule

`default_nettype wire

// File: tb/tb_lsu_dmem_ctrl.sv
// ============================================================================
// tb_lsu_dmem_ctrl : directed + random bench with a word-array memory model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lsu_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_is_store = 1'b0;
  logic [2:0]  i_req_funct3 = 3'd0;
  logic [31:0] i_req_addr = 32'd0;
  logic [31:0] i_req_wdata = 32'd0;
  logic [5:0]  i_req_tag = 6'd0;
  logic        o_resp_valid;
  logic        i_resp_ready = 1'b0;
  logic [5:0]  o_resp_tag;
  logic [31:0] o_resp_data;
  logic        o_resp_misaligned;
  logic        o_resp_illegal;
  logic        i_flush = 1'b0;
  logic [31:0] o_dmem_addr;
  logic        o_dmem_wr_en;
  logic [31:0] o_dmem_wr_data;
  logic [31:0] i_dmem_rd_data;

  int total = 0;
  int bad   = 0;

  logic [31:0] dm [0:255];   // the memory the DUT talks to
  logic [31:0] rm [0:255];   // reference copy updated from the access rules

  lsu_dmem_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .i_req_valid       (i_req_valid),
    .o_req_ready       (o_req_ready),
    .i_req_is_store    (i_req_is_store),
    .i_req_funct3      (i_req_funct3),
    .i_req_addr        (i_req_addr),
    .i_req_wdata       (i_req_wdata),
    .i_req_tag         (i_req_tag),
    .o_resp_valid      (o_resp_valid),
    .i_resp_ready      (i_resp_ready),
    .o_resp_tag        (o_resp_tag),
    .o_resp_data       (o_resp_data),
    .o_resp_misaligned (o_resp_misaligned),
    .o_resp_illegal    (o_resp_illegal),
    .i_flush           (i_flush),
    .o_dmem_addr       (o_dmem_addr),
    .o_dmem_wr_en      (o_dmem_wr_en),
    .o_dmem_wr_data    (o_dmem_wr_data),
    .i_dmem_rd_data    (i_dmem_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_dmem_wr_en) dm[o_dmem_addr[7:0]] <= o_dmem_wr_data;
    i_dmem_rd_data <= dm[o_dmem_addr[7:0]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic logic ref_legal(input logic st, input logic [2:0] f3);
    if (st) return f3 <= 3'd2;
    return (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
  endfunction

  function automatic int ref_size(input logic [2:0] f3);
    return int'(f3 % 4);   // 0 byte, 1 half, 2 word
  endfunction

  function automatic logic ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = ref_size(f3);
    return (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] w, input logic [31:0] a);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) & 32'h000000FF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'h0000FFFF;
    case (f3)
      3'd0:    return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      3'd2:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [2:0] f3, input logic [31:0] old,
                                            input logic [31:0] wd, input logic [31:0] a);
    logic [31:0] mask;
    int          sh;
    case (ref_size(f3))
      0:       begin sh = 8 * int'(a % 4);         mask = 32'h000000FF << sh; end
      1:       begin sh = 16 * int'((a / 2) % 2);  mask = 32'h0000FFFF << sh; end
      default: begin sh = 0;                       mask = 32'hFFFFFFFF;       end
    endcase
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  // One full transaction: issue, watch dmem writes, check response and handshake.
  // flush_k > 0 raises i_flush during that cycle after accept (cycle 1 = T+1).
  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [5:0] tg,
                         input int hold, input int flush_k);
    logic        legal, mis, fault, cancel;
    int          lat, wr_cyc, k, n, nwr;
    logic [31:0] widx, exp_data, exp_word;
    legal    = ref_legal(st, f3);
    mis      = legal && ref_misaligned(f3, a);
    fault    = !legal || mis;
    widx     = a / 4;
    exp_data = (!st && !fault) ? ref_load(f3, rm[widx[7:0]], a) : 32'd0;
    exp_word = ref_store(f3, rm[widx[7:0]], wd, a);
    lat      = fault ? 1 : (st && f3 == 3'd2) ? 2 : 3;
    wr_cyc   = (st && !fault) ? lat - 1 : 0;
    cancel   = !st && (flush_k > 0) && (flush_k < lat);

    n = 0;
    while (!o_req_ready && n < 20) begin @(posedge clk); #1; n++; end
    check("req_ready_before_issue", {31'd0, o_req_ready}, 32'd1);
    i_req_valid = 1'b1; i_req_is_store = st; i_req_funct3 = f3;
    i_req_addr = a; i_req_wdata = wd; i_req_tag = tg;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    i_resp_ready = (hold == 0);
    k = 1; nwr = 0;
    while (k <= 12) begin
      i_flush = (k == flush_k);
      #0;
      if (o_dmem_wr_en) begin
        nwr++;
        check("wr_cycle", k, wr_cyc);
        check("wr_addr", o_dmem_addr, widx);
        check("wr_data", o_dmem_wr_data, exp_word);
      end
      if (o_resp_valid) break;
      if (cancel && k == flush_k) begin
        @(posedge clk); #1;
        i_flush = 1'b0;
        check("flush_no_resp", {31'd0, o_resp_valid}, 32'd0);
        check("flush_ready", {31'd0, o_req_ready}, 32'd1);
        check("flush_no_write", nwr, 0);
        return;
      end
      @(posedge clk); #1;
      k++;
    end
    i_flush = 1'b0;
    check("resp_latency", k, lat);
    check("resp_tag", {26'd0, o_resp_tag}, {26'd0, tg});
    check("resp_data", o_resp_data, exp_data);
    check("resp_misaligned", {31'd0, o_resp_misaligned}, {31'd0, mis});
    check("resp_illegal", {31'd0, o_resp_illegal}, {31'd0, !legal});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'd0, o_resp_valid}, 32'd1);
      check("hold_tag", {26'd0, o_resp_tag}, {26'd0, tg});
      check("hold_data", o_resp_data, exp_data);
      check("hold_flags", {30'd0, o_resp_misaligned, o_resp_illegal}, {30'd0, mis, !legal});
      check("hold_req_ready", {31'd0, o_req_ready}, 32'd0);
      if (o_dmem_wr_en) nwr++;
    end
    i_resp_ready = 1'b1;
    @(posedge clk); #1;
    i_resp_ready = 1'b0;
    check("resp_consumed", {31'd0, o_resp_valid}, 32'd0);
    check("ready_after_resp", {31'd0, o_req_ready}, 32'd1);
    check("write_count", nwr, (st && !fault) ? 1 : 0);
    if (st && !fault) rm[widx[7:0]] = exp_word;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_resp_valid"}, {31'd0, o_resp_valid}, 32'd0);
    check({name, "_wr_en"}, {31'd0, o_dmem_wr_en}, 32'd0);
    check({name, "_dmem_addr"}, o_dmem_addr, 32'd0);
    check({name, "_wr_data"}, o_dmem_wr_data, 32'd0);
    check({name, "_resp_tag"}, {26'd0, o_resp_tag}, 32'd0);
    check({name, "_resp_data"}, o_resp_data, 32'd0);
    check({name, "_flags"}, {30'd0, o_resp_misaligned, o_resp_illegal}, 32'd0);
    check({name, "_req_ready"}, {31'd0, o_req_ready}, 32'd0);
  endtask

  initial begin
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) begin
      dm[i] = $urandom;
      rm[i] = dm[i];
    end
    dm[16] = 32'h8899AABB; rm[16] = 32'h8899AABB;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    #1;
    check("ready_after_reset", {31'd0, o_req_ready}, 32'd1);

    // Loads from the preloaded word
    run_req(1'b0, 3'd0, 32'h43, 32'd0, 6'd5, 0, 0);
    run_req(1'b0, 3'd4, 32'h41, 32'd0, 6'd6, 0, 0);
    run_req(1'b0, 3'd5, 32'h42, 32'd0, 6'd7, 0, 0);
    run_req(1'b0, 3'd1, 32'h40, 32'd0, 6'd8, 0, 0);
    run_req(1'b0, 3'd2, 32'h40, 32'd0, 6'd9, 0, 0);

    // Sub-word stores via read-modify-write, then word store and readback
    run_req(1'b1, 3'd0, 32'h41, 32'h12345677, 6'd10, 0, 0);
    check("mem_after_sb", dm[16], 32'h889977BB);
    run_req(1'b1, 3'd1, 32'h42, 32'h0000CAFE, 6'd11, 0, 0);
    check("mem_after_sh", dm[16], 32'hCAFE77BB);
    run_req(1'b1, 3'd2, 32'h44, 32'hDEADBEEF, 6'd12, 0, 0);
    run_req(1'b0, 3'd2, 32'h44, 32'd0, 6'd13, 0, 0);

    // Faults
    run_req(1'b0, 3'd2, 32'h42, 32'd0, 6'd14, 0, 0);
    run_req(1'b0, 3'd1, 32'h41, 32'd0, 6'd15, 0, 0);
    run_req(1'b0, 3'd3, 32'h41, 32'd0, 6'd16, 0, 0);
    run_req(1'b1, 3'd4, 32'h40, 32'h11111111, 6'd17, 0, 0);
    run_req(1'b1, 3'd2, 32'h46, 32'h22222222, 6'd18, 0, 0);

    // Backpressure, flush of a load, flush ignored by a store
    run_req(1'b0, 3'd2, 32'h40, 32'd0, 6'd19, 4, 0);
    run_req(1'b0, 3'd0, 32'h40, 32'd0, 6'd20, 0, 1);
    run_req(1'b0, 3'd2, 32'h44, 32'd0, 6'd21, 0, 2);
    run_req(1'b1, 3'd0, 32'h45, 32'h000000A5, 6'd22, 0, 1);
    run_req(1'b0, 3'd2, 32'h44, 32'd0, 6'd23, 0, 0);

    // Reset pulse while the RMW write is on the bus; the write must be dropped
    i_req_valid = 1'b1; i_req_is_store = 1'b1; i_req_funct3 = 3'd0;
    i_req_addr = 32'h48; i_req_wdata = 32'h0000005A; i_req_tag = 6'd24;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    @(posedge clk); #1;
    check("rmw_wr_en_before_reset", {31'd0, o_dmem_wr_en}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    check("midrst_wr_en_edge", {31'd0, o_dmem_wr_en}, 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_midrst", {31'd0, o_req_ready}, 32'd1);
    run_req(1'b0, 3'd2, 32'h48, 32'd0, 6'd25, 0, 0);

    // Random traffic against the reference memory
    for (int i = 0; i < 60; i++) begin
      st = $urandom_range(0, 1);
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
      a  = $urandom_range(0, 1023);
      if ($urandom_range(0, 2) != 0) a = a & ~(32'(f3 % 4) * 32'd1 + (f3 % 4 == 2 ? 32'd1 : 32'd0));
      run_req(st, f3, a, $urandom, 6'($urandom), $urandom_range(0, 2),
              ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
